jt51_mixacc: RTL and testbench
==============================

JT51_MIXACC -- requirements
Module: jt51_mixacc

Interface
REQ-001 Parameter OPW, default 14: operator sample width, signed two's complement.
REQ-002 Parameter ACCW, default 16: channel accumulator width and output width, signed.
REQ-003 Parameter CH, default 8: number of channels.
REQ-004 Parameter CHW, default 3: channel index width; CH SHALL NOT exceed 2**CHW.
REQ-005 Port clk, input, 1: system clock; all state SHALL change on the rising edge only.
REQ-006 Port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 Port cen, input, 1: clock enable; one slot is processed per rising edge with cen=1.
REQ-008 Port zero, input, 1: the current slot is the first slot of a new frame.
REQ-009 Port op_out, input, OPW: signed operator output for the current slot.
REQ-010 Port op_en, input, 1: the current slot's operator contributes to its channel sum.
REQ-011 Port op_last, input, 1: the current slot is the last slot of its channel in this frame.
REQ-012 Port ch, input, CHW: channel index of the current slot.
REQ-013 Port rl, input, 2: pan for the current channel; bit 1 enables right, bit 0 enables left.
REQ-014 Port mute, input, CH: per-channel mute mask; bit n set drops channel n from the mix.
REQ-015 Port left, output, ACCW: signed saturated left sample, registered.
REQ-016 Port right, output, ACCW: signed saturated right sample, registered.
REQ-017 Port sample, output, 1: single-clk pulse marking a new left/right pair.

Function
REQ-018 The block SHALL hold CH channel accumulators cacc[0..CH-1] of ACCW bits each, plus frame accumulators fl and fr of ACCW+CHW bits each.
REQ-019 On an edge with cen=1, the channel term SHALL be t = sat_ACCW(cacc[ch] + sext(op_out)) when op_en=1, and t = cacc[ch] otherwise.
REQ-020 sat_W SHALL clamp to [-2**(W-1), 2**(W-1)-1]; wrap-around SHALL never occur in cacc, left or right.
REQ-021 With op_last=0, the edge SHALL store cacc[ch] <= t.
REQ-022 With op_last=1, the edge SHALL store cacc[ch] <= 0, and t SHALL be added to fl when rl[0]=1 and to fr when rl[1]=1, unless mute[ch]=1.
REQ-023 On an edge with cen=1 and zero=1, the block SHALL store left <= sat_ACCW(fl) and right <= sat_ACCW(fr), using fl and fr before this slot's contribution.
REQ-024 On that same edge, fl and fr SHALL restart at this slot's contribution (0 if none), so the zero slot belongs to the new frame.
REQ-025 sample SHALL be 1 for exactly the clk cycle following an edge with cen=1 and zero=1, and 0 otherwise, including while cen=0.
REQ-026 Latency: a contribution made in frame k SHALL appear on left/right at the zero edge that starts frame k+1.
REQ-027 No state other than sample SHALL change on an edge with cen=0.
REQ-028 An out-of-range ch (ch >= CH) SHALL neither modify any state nor contribute to the mix.
REQ-029 With mute[ch]=1 and op_last=1, cacc[ch] SHALL still be cleared.

Reset
REQ-030 While rst=1 at an edge, cacc[*], fl, fr, left, right and sample SHALL all become 0, regardless of cen.
REQ-031 A reset mid-frame SHALL discard the partial frame; the first zero edge after reset SHALL output only the contributions made since reset.

Verification
REQ-032 Defaults; in one frame, ch 0 has four op_en slots of 1000 (last with op_last), rl=11; next zero edge -> left=right=4000, sample high for 1 cycle.
REQ-033 Saturation: ch 2 has four op_en slots of 8191, ACCW=16, rl=01 -> cacc peaks at 32764; plus ch 3 contributing 8191 on the left -> left=32767, right=0.
REQ-034 Negative clamp: all 8 channels end at -32768 with rl=11 -> left=right=-32768, with no wrap.
REQ-035 Mute and pan: ch 1=500 rl=10, ch 4=700 rl=01, mute[4]=1 -> right=500, left=0; cacc[4]=0 afterwards.
REQ-036 Simultaneous: op_last on the zero slot with value 300, rl=11 -> outputs exclude 300; the following frame's outputs include 300.
REQ-037 Reset: assert rst mid-frame after ch 0 has accumulated 2000 -> left=right=0 and sample=0 at once; the next zero edge outputs 0.

Source files
------------

// File: rtl/jt51_mixacc.sv
// Per-channel operator accumulators feeding a stereo frame mixer with saturation.
// Left/right are registered at each zero slot; sample pulses for one clk afterwards.
module jt51_mixacc #(
  parameter int OPW  = 14,
  parameter int ACCW = 16,
  parameter int CH   = 8,
  parameter int CHW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic signed [OPW-1:0]  op_out,
  input  logic                   op_en,
  input  logic                   op_last,
  input  logic [CHW-1:0]         ch,
  input  logic [1:0]             rl,
  input  logic [CH-1:0]          mute,
  output logic signed [ACCW-1:0] left,
  output logic signed [ACCW-1:0] right,
  output logic                   sample
);

  localparam int FW = ACCW + CHW;
  localparam logic signed [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  logic signed [ACCW-1:0] r_cacc [CH];
  logic signed [FW-1:0]   r_fl, r_fr;

  logic                   w_ok, w_mute, w_add;
  logic signed [ACCW-1:0] w_cur, w_t;
  logic signed [ACCW:0]   w_sum;
  logic signed [FW-1:0]   w_cl, w_cr, w_fl_nxt, w_fr_nxt;

  function automatic logic signed [ACCW-1:0] sat_frame(input logic signed [FW-1:0] x);
    if ((&x[FW-1:ACCW-1]) || !(|x[FW-1:ACCW-1]))
      return $signed(x[ACCW-1:0]);
    else
      return x[FW-1] ? MINV : MAXV;
  endfunction

  // Channel decode by match keeps out-of-range ch from touching any accumulator.
  always_comb begin
    w_ok   = 1'b0;
    w_mute = 1'b0;
    w_cur  = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch == CHW'(i)) begin
        w_ok   = 1'b1;
        w_mute = mute[i];
        w_cur  = r_cacc[i];
      end
    end
  end

  always_comb begin
    w_sum = {w_cur[ACCW-1], w_cur} + (ACCW+1)'(op_out);
    w_t   = w_cur;
    if (op_en) begin
      if (w_sum[ACCW] != w_sum[ACCW-1])
        w_t = w_sum[ACCW] ? MINV : MAXV;
      else
        w_t = $signed(w_sum[ACCW-1:0]);
    end
    w_add    = w_ok && op_last && !w_mute;
    w_cl     = (w_add && rl[0]) ? FW'(w_t) : '0;
    w_cr     = (w_add && rl[1]) ? FW'(w_t) : '0;
    w_fl_nxt = (zero ? '0 : r_fl) + w_cl;
    w_fr_nxt = (zero ? '0 : r_fr) + w_cr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) r_cacc[i] <= '0;
      r_fl   <= '0;
      r_fr   <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else begin
      sample <= cen && zero;
      if (cen) begin
        r_fl <= w_fl_nxt;
        r_fr <= w_fr_nxt;
        if (zero) begin
          left  <= sat_frame(r_fl);
          right <= sat_frame(r_fr);
        end
        for (int i = 0; i < CH; i++) begin
          if (w_ok && ch == CHW'(i))
            r_cacc[i] <= op_last ? '0 : w_t;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt51_mixacc.sv
// Bench for jt51_mixacc: directed frames plus random slots against an integer mixing model.
module tb_jt51_mixacc;

  logic               clk = 1'b0;
  logic               rst, cen, zero, op_en, op_last;
  logic signed [13:0] op_out;
  logic [2:0]         ch;
  logic [1:0]         rl;
  logic [7:0]         mute;
  logic signed [15:0] left, right;
  logic               sample;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  int m_cacc [8];
  int m_fl, m_fr, m_left, m_right;
  int m_sample;

  jt51_mixacc dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .op_out(op_out),
    .op_en(op_en), .op_last(op_last), .ch(ch), .rl(rl), .mute(mute),
    .left(left), .right(right), .sample(sample)
  );

  always #5 clk = ~clk;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [32:0] exp_vec();
    logic signed [15:0] l, r;
    l = 16'(m_left);
    r = 16'(m_right);
    return {l, r, m_sample[0]};
  endfunction

  task automatic model_edge();
    int cur, t, cl, cr, c;
    if (rst) begin
      foreach (m_cacc[i]) m_cacc[i] = 0;
      m_fl = 0; m_fr = 0; m_left = 0; m_right = 0; m_sample = 0;
      return;
    end
    m_sample = (cen && zero) ? 1 : 0;
    if (!cen) return;
    c   = int'(ch);
    cur = m_cacc[c];
    t   = op_en ? clamp16(cur + int'(op_out)) : cur;
    cl  = (op_last && !mute[c] && rl[0]) ? t : 0;
    cr  = (op_last && !mute[c] && rl[1]) ? t : 0;
    if (zero) begin
      m_left  = clamp16(m_fl);
      m_right = clamp16(m_fr);
      m_fl = cl;
      m_fr = cr;
    end else begin
      m_fl += cl;
      m_fr += cr;
    end
    m_cacc[c] = op_last ? 0 : t;
  endtask

  task automatic slot(input logic z, input logic en, input logic last, input int c,
                      input int op, input logic [1:0] p, input logic [7:0] m, input logic ce);
    zero = z; op_en = en; op_last = last; ch = 3'(c); op_out = 14'(op);
    rl = p; mute = m; cen = ce;
    @(posedge clk);
    model_edge();
    #1;
    cen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    slot(1, 1, 0, 0, 123, 2'b11, 8'h00, 1);
    slot(0, 1, 0, 0, 55, 2'b11, 8'h00, 0);
    rst = 1'b0;
    n_cmp++;
    if ({left, right, sample} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset: got l=%0d r=%0d s=%0b want 0 0 0", left, right, sample);
    end
  endtask

  task automatic test_basic();
    slot(1, 1, 0, 0, 1000, 2'b11, 8'h00, 1);
    slot(0, 1, 0, 0, 1000, 2'b11, 8'h00, 1);
    slot(0, 1, 0, 0, 1000, 2'b11, 8'h00, 1);
    slot(0, 1, 1, 0, 1000, 2'b11, 8'h00, 1);
    slot(1, 0, 0, 5, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right, sample} !== {16'sd4000, 16'sd4000, 1'b1}) begin
      n_bad++;
      $display("FAIL basic: got l=%0d r=%0d s=%0b want 4000 4000 1", left, right, sample);
    end
    slot(0, 0, 0, 5, 0, 2'b00, 8'h00, 0);
    n_cmp++;
    if (sample !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: got s=%0b want 0", sample);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) slot(0, 1, i == 3, 2, 8191, 2'b01, 8'h00, 1);
    slot(0, 1, 1, 3, 8191, 2'b01, 8'h00, 1);
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right, sample} !== {16'sd32767, 16'sd0, 1'b1}) begin
      n_bad++;
      $display("FAIL saturation: got l=%0d r=%0d want 32767 0", left, right);
    end
  endtask

  task automatic test_neg_clamp();
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 5; i++) slot(0, 1, i == 4, c, -8192, 2'b11, 8'h00, 1);
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right} !== {-16'sd32768, -16'sd32768}) begin
      n_bad++;
      $display("FAIL neg_clamp: got l=%0d r=%0d want -32768 -32768", left, right);
    end
  endtask

  task automatic test_mute_pan();
    slot(0, 1, 1, 1, 500, 2'b10, 8'h10, 1);
    slot(0, 1, 0, 4, 350, 2'b01, 8'h10, 1);
    slot(0, 1, 1, 4, 350, 2'b01, 8'h10, 1);
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right} !== {16'sd0, 16'sd500}) begin
      n_bad++;
      $display("FAIL mute_pan: got l=%0d r=%0d want 0 500", left, right);
    end
    // ch 4 must have been cleared despite the mute
    slot(0, 0, 1, 4, 0, 2'b01, 8'h00, 1);
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right} !== {16'sd0, 16'sd0}) begin
      n_bad++;
      $display("FAIL mute_clear: got l=%0d r=%0d want 0 0", left, right);
    end
  endtask

  task automatic test_simultaneous();
    slot(1, 1, 1, 2, 300, 2'b11, 8'h00, 1);
    n_cmp++;
    if ({left, right, sample} !== {16'sd0, 16'sd0, 1'b1}) begin
      n_bad++;
      $display("FAIL simul_excl: got l=%0d r=%0d want 0 0", left, right);
    end
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right} !== {16'sd300, 16'sd300}) begin
      n_bad++;
      $display("FAIL simul_incl: got l=%0d r=%0d want 300 300", left, right);
    end
  endtask

  task automatic test_cen_gap();
    slot(0, 1, 1, 0, 777, 2'b11, 8'h00, 1);
    for (int i = 0; i < 4; i++)
      slot(1, 1, 1, i, 4000, 2'b11, 8'h00, 0);
    n_cmp++;
    if ({left, right, sample} !== exp_vec()) begin
      n_bad++;
      $display("FAIL cen_gap: got l=%0d r=%0d s=%0b want %0d %0d %0d",
               left, right, sample, m_left, m_right, m_sample);
    end
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right} !== {16'sd777, 16'sd777}) begin
      n_bad++;
      $display("FAIL cen_gap_out: got l=%0d r=%0d want 777 777", left, right);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 3000; n++) begin
      slot($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7),
           $urandom_range(0, 16383) - 8192, 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255) & $urandom_range(0, 255)),
           $urandom_range(0, 3) != 0);
      n_cmp++;
      if ({left, right, sample} !== exp_vec()) begin
        n_bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d]: got l=%0d r=%0d s=%0b want %0d %0d %0d",
                   n, left, right, sample, m_left, m_right, m_sample);
      end
    end
  endtask

  task automatic test_reset_mid();
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    slot(0, 1, 0, 0, 1000, 2'b11, 8'h00, 1);
    slot(0, 1, 0, 0, 1000, 2'b11, 8'h00, 1);
    slot(0, 0, 1, 5, 0, 2'b11, 8'h00, 1);
    rst = 1'b1;
    slot(0, 0, 0, 0, 0, 2'b00, 8'h00, 1);
    rst = 1'b0;
    n_cmp++;
    if ({left, right, sample} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got l=%0d r=%0d s=%0b want 0 0 0", left, right, sample);
    end
    slot(0, 0, 1, 0, 0, 2'b11, 8'h00, 1);
    slot(1, 0, 0, 6, 0, 2'b00, 8'h00, 1);
    n_cmp++;
    if ({left, right, sample} !== {16'sd0, 16'sd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_frame: got l=%0d r=%0d s=%0b want 0 0 1", left, right, sample);
    end
  endtask

  initial begin
    rst = 1'b0; cen = 1'b0; zero = 1'b0; op_en = 1'b0; op_last = 1'b0;
    op_out = '0; ch = '0; rl = '0; mute = '0;
    #2;
    test_reset();
    test_basic();
    test_saturation();
    test_neg_clamp();
    test_mute_pan();
    test_simultaneous();
    test_cen_gap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
